// File: rtl/bus_matrix.sv
// bus_matrix: N-master to N-slave shared bus with one registered owner.
// The owner's address, strobe, rw and write data are muxed onto the common slave
// bus. The slave index comes from the top address bits. A watchdog ends any
// access that no slave answers within TIMEOUT cycles.
module bus_matrix #(
  parameter int          N_MASTERS = 4,
  parameter int          N_SLAVES  = 8,
  parameter int          ADDR_W    = 30,
  parameter int          DATA_W    = 32,
  parameter int          ARB_MODE  = 0,
  parameter logic [15:0] TIMEOUT   = 16'd255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_MASTERS-1:0]                 m_req_,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS-1:0]                 m_as_,
  input  logic [N_MASTERS-1:0]                 m_rw,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]     m_wr_data,
  output logic [N_MASTERS-1:0]                 m_grnt_,
  output logic [DATA_W-1:0]                    m_rd_data,
  output logic                                 m_rdy_,
  output logic                                 m_err,
  output logic [ADDR_W-1:0]                    s_addr,
  output logic                                 s_as_,
  output logic                                 s_rw,
  output logic [DATA_W-1:0]                    s_wr_data,
  output logic [N_SLAVES-1:0]                  s_cs_,
  input  logic [N_SLAVES-1:0][DATA_W-1:0]      s_rd_data,
  input  logic [N_SLAVES-1:0]                  s_rdy_
);
  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int OWN_W = $clog2(N_MASTERS);

  logic [OWN_W-1:0] owner, owner_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic [SEL_W-1:0] sel;
  logic             slv_rdy_;
  logic             tmo;
  logic             busy;

  // Master-side mux straight from the owner register.
  assign s_addr    = m_addr[owner];
  assign s_as_     = m_as_[owner];
  assign s_rw      = m_rw[owner];
  assign s_wr_data = m_wr_data[owner];

  assign sel      = s_addr[ADDR_W-1 -: SEL_W];
  assign slv_rdy_ = s_rdy_[sel];

  // Grant is a pure decode of the owner, so exactly one bit is ever low.
  // Chip selects decode the address alone and ignore the strobe.
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_grnt
      assign m_grnt_[gi] = (owner != OWN_W'(gi));
    end
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_cs
      assign s_cs_[gi] = (sel != SEL_W'(gi));
    end
  endgenerate

  // Watchdog termination. Reset masks it so an abandoned access never pulses
  // m_err. A real slave ready wins over the watchdog.
  assign tmo       = (TIMEOUT != 16'd0) && !reset && (cnt == TIMEOUT) && !s_as_ && slv_rdy_;
  assign m_err     = tmo;
  assign m_rdy_    = slv_rdy_ & ~tmo;
  assign m_rd_data = tmo ? '0 : s_rd_data[sel];

  // An access is open while the strobe is low and this is not its final cycle.
  assign busy = !s_as_ && m_rdy_;

  // Next owner. Lock during an open access, hold while the owner still requests,
  // otherwise re-arbitrate, and park on the current owner if nobody requests.
  // The lowest-priority candidate is scanned first and later matches overwrite
  // it, so the highest-priority requester is the one that remains.
  always_comb begin
    owner_nxt = owner;
    if (!busy && m_req_[owner]) begin
      if (ARB_MODE == 0) begin
        for (int i = N_MASTERS - 1; i >= 0; i--)
          if (!m_req_[OWN_W'(i)]) owner_nxt = OWN_W'(i);
      end else begin
        for (int k = N_MASTERS; k >= 1; k--)
          if (!m_req_[OWN_W'((int'(owner) + k) % N_MASTERS)])
            owner_nxt = OWN_W'((int'(owner) + k) % N_MASTERS);
      end
    end
  end

  // Timeout counter. It restarts on idle, on termination or on a handover,
  // and otherwise saturates at TIMEOUT.
  always_comb begin
    cnt_nxt = cnt;
    if (s_as_ || !m_rdy_ || (owner_nxt != owner)) cnt_nxt = '0;
    else if (cnt != TIMEOUT)                       cnt_nxt = cnt + 16'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= '0;
      cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule
